instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle program sequencer for the 9-bit-instruction core.
- Owns the program counter and the Start/Done handshake; decides per cycle whether the decoded instruction commits.
- Inserts wait states for loads and applies branch/jump targets from the branch LUT.
- Sits between instruction ROM, control decoder, ALU flags and the register file/data-memory write enables.

Parameters:
- PC_W, 10, program counter width; instruction ROM depth is 2^PC_W.
- LD_LAT, 1, data-memory read wait states per load (0..7).
- START_PC, 0, PC value loaded on Start.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  level; high requests program (re)start.
- Branch  in  1  decoder: current instruction is branch/jump.
- Immed  in  1  decoder: unconditional jump (ignore Taken).
- Taken  in  1  ALU flag result for a conditional branch.
- MemtoReg  in  1  decoder: current instruction is a load.
- MemWrite  in  1  decoder: current instruction is a store.
- Halt  in  1  decoder: current instruction is halt.
- Target  in  PC_W  absolute target from the branch LUT.
- PC  out  PC_W  instruction ROM address.
- CommitEn  out  1  gates RegWrite/MemWrite/FlagWrite; high = current instruction retires this cycle.
- MemWriteEn  out  1  MemWrite AND CommitEn.
- Done  out  1  program finished.

Behaviour:
- Reset (synchronous, active-high), all take effect on the next Clk edge:
  - state=IDLE, PC=START_PC, Done=0, wait counter=0.
  - CommitEn=0, MemWriteEn=0.
  - Reset overrides every other input, including mid-load.
- States:
  - IDLE: CommitEn=0. Start=1 -> RUN next cycle with PC=START_PC. Start=0 -> stay.
  - RUN (default): CommitEn=1 and PC<=next_pc, except in these cases:
    - Halt=1: CommitEn=0; PC holds; -> HALT; Done=1 from the next cycle. Halt has priority over Branch and MemtoReg.
    - MemtoReg=1 and LD_LAT>0: CommitEn=0; PC holds; wait counter<=LD_LAT-1; -> LOAD_WAIT.
    - MemtoReg=1 and LD_LAT=0: commits in one cycle, like any other instruction.
  - LOAD_WAIT: CommitEn=0 while counter!=0, counter decrements. When counter==0: CommitEn=1, PC<=PC+1, -> RUN. A load therefore occupies LD_LAT+1 cycles; all other instructions occupy 1.
  - HALT: Done=1, CommitEn=0, PC holds. Start=1 -> Done<=0, PC<=START_PC, -> RUN.
- next_pc rule:
  - Branch=1 and (Immed=1 or Taken=1): Target.
  - Otherwise: PC+1, modulo 2^PC_W (2^PC_W-1 wraps to 0, no flag).
- Start while in RUN or LOAD_WAIT: abort the program.
  - Next cycle: PC=START_PC, state RUN, wait counter cleared.
  - The in-flight instruction does not commit (CommitEn=0 in the Start cycle).
- Start held high: restart is level-sensitive, so PC stays at START_PC until Start drops. The first commit occurs in the first RUN cycle with Start=0.
- Outputs:
  - PC and Done are registered.
  - CommitEn and MemWriteEn are combinational from state, counter, Start and the decoder inputs.
- Branch and load flags together (illegal encoding): load rule applies; the branch is evaluated on the commit cycle.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined: adds output CycleCnt[15:0] and output RetireCnt[15:0].
  - Both clear on Reset and on a Start-triggered transition into RUN.
  - CycleCnt increments every cycle in RUN or LOAD_WAIT.
  - RetireCnt increments on every CommitEn=1 cycle.
  - Both saturate at 16'hFFFF and freeze in HALT.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package seq_pkg holds:
  - enum state_t {IDLE, RUN, LOAD_WAIT, HALT} (2 bits).
  - Localparam widths for the wait counter (3 bits) and perf counters (16).
- One natural sub-module, seq_pc: PC register plus next-PC mux (increment/wrap, branch target, restart load). The FSM stays in instr_sequencer.

Test Plan:
- Reset then Start=1 for 2 cycles then 0 -> PC=0, Done=0. CommitEn first high in the first cycle with Start=0. PC=1,2,3 on successive straight-line cycles.
- LD_LAT=2, load at PC=5 -> CommitEn pattern 0,0,1 over 3 cycles; PC stays 5 then becomes 6. A store at PC=6 gives MemWriteEn=1 in a single cycle.
- Conditional branch at PC=8, Target=20:
  - Taken=0 -> PC=9.
  - Taken=1 -> PC=20.
  - Immed=1 with Taken=0 -> PC=20.
- PC_W=4, PC=15 straight-line -> PC=0. Halt together with Branch=1 at PC=3 -> PC holds 3, Done=1 next cycle and stays until Start.
- Start pulse during LOAD_WAIT at PC=12 -> CommitEn=0 that cycle, next PC=0, state RUN. Reset asserted mid-LOAD_WAIT -> IDLE, PC=0, Done=0.
- With SEQ_PERF_CNT_EN: program of 3 ALU ops + 1 load (LD_LAT=1) + halt -> RetireCnt=4, CycleCnt=6 (including the halt cycle), both frozen in HALT.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and widths for the instruction sequencer.
// No logic here; no latency or backpressure of its own.
package seq_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    LOAD_WAIT = 2'd2,
    HALT      = 2'd3
  } state_t;

  localparam int CNT_W  = 3;
  localparam int PERF_W = 16;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);
  localparam logic [PERF_W-1:0] PERF_MAX = '1;
endpackage

// File: rtl/seq_pc.sv
// Program counter register with next-PC mux (restart load, branch target, wrapping increment).
// PC updates one cycle after restart/advance; holds whenever neither is asserted.
module seq_pc #(
  parameter int PC_W     = 10,
  parameter int START_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            restart,
  input  logic            advance,
  input  logic            take,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);
  localparam logic [PC_W-1:0] START_V = PC_W'(START_PC);
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] pc_q;

  // Restart beats advance so an aborted instruction never moves the PC.
  always_comb begin
    pc_d = pc_q;
    if (restart) begin
      pc_d = START_V;
    end else if (advance) begin
      pc_d = take ? target : pc_q + PC_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= START_V;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;
endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: PC/Start/Done control, load wait states, branch commit gating.
// PC and Done registered; CommitEn/MemWriteEn combinational. Optional SEQ_PERF_CNT_EN adds cycle/retire counters.
module instr_sequencer #(
  parameter int PC_W     = 10,
  parameter int LD_LAT   = 1,
  parameter int START_PC = 0
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Branch,
  input  logic            Immed,
  input  logic            Taken,
  input  logic            MemtoReg,
  input  logic            MemWrite,
  input  logic            Halt,
  input  logic [PC_W-1:0] Target,
  output logic [PC_W-1:0] PC,
  output logic            CommitEn,
  output logic            MemWriteEn,
`ifdef SEQ_PERF_CNT_EN
  output logic [15:0]     CycleCnt,
  output logic [15:0]     RetireCnt,
`endif
  output logic            Done
);
  import seq_pkg::*;

  localparam logic [CNT_W-1:0] LD_WAIT_INIT = CNT_W'((LD_LAT > 0) ? LD_LAT - 1 : 0);

  state_t           state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             done_d, done_q;
  logic             commit;
  logic             restart;
  logic             advance;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    commit  = 1'b0;
    restart = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          restart = 1'b1;
        end
      end
      RUN: begin
        if (Start) begin
          restart = 1'b1;
          cnt_d   = '0;
        end else if (Halt) begin
          state_d = HALT;
          done_d  = 1'b1;
        end else if (MemtoReg && (LD_LAT > 0)) begin
          state_d = LOAD_WAIT;
          cnt_d   = LD_WAIT_INIT;
        end else begin
          commit  = 1'b1;
          advance = 1'b1;
        end
      end
      LOAD_WAIT: begin
        // A branch flag riding on a load is honoured here, on the commit cycle.
        if (Start) begin
          state_d = RUN;
          restart = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = RUN;
          commit  = 1'b1;
          advance = 1'b1;
        end
      end
      HALT: begin
        if (Start) begin
          state_d = RUN;
          done_d  = 1'b0;
          restart = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  seq_pc #(
    .PC_W     (PC_W),
    .START_PC (START_PC)
  ) u_pc (
    .clk     (Clk),
    .rst     (Reset),
    .restart (restart),
    .advance (advance),
    .take    (Branch & (Immed | Taken)),
    .target  (Target),
    .pc      (PC)
  );

  assign CommitEn   = commit;
  assign MemWriteEn = MemWrite & commit;
  assign Done       = done_q;

`ifdef SEQ_PERF_CNT_EN
  logic [PERF_W-1:0] cyc_d, cyc_q;
  logic [PERF_W-1:0] ret_d, ret_q;

  // Every Start leads into RUN, so Start alone is the clear; HALT never counts, hence frozen.
  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    if (Start) begin
      cyc_d = '0;
      ret_d = '0;
    end else begin
      if ((state_q == RUN || state_q == LOAD_WAIT) && cyc_q != PERF_MAX) begin
        cyc_d = cyc_q + PERF_ONE;
      end
      if (commit && ret_q != PERF_MAX) begin
        ret_d = ret_q + PERF_ONE;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign CycleCnt  = cyc_q;
  assign RetireCnt = ret_q;
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: wide config (PC_W=10, LD_LAT=2) and narrow config (PC_W=4, LD_LAT=1).
module tb_instr_sequencer;
  logic Clk;
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       a_rst, a_start, a_br, a_imm, a_tk, a_ld, a_st, a_halt;
  logic [9:0] a_tgt, a_pc;
  logic       a_commit, a_mwe, a_done;
  logic       b_rst, b_start, b_br, b_imm, b_tk, b_ld, b_st, b_halt;
  logic [3:0] b_tgt, b_pc;
  logic       b_commit, b_mwe, b_done;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0] a_cyc, a_ret, b_cyc, b_ret;
`endif

  instr_sequencer #(.PC_W(10), .LD_LAT(2), .START_PC(0)) dut_a (
    .Clk(Clk), .Reset(a_rst), .Start(a_start), .Branch(a_br), .Immed(a_imm),
    .Taken(a_tk), .MemtoReg(a_ld), .MemWrite(a_st), .Halt(a_halt), .Target(a_tgt),
    .PC(a_pc), .CommitEn(a_commit), .MemWriteEn(a_mwe),
`ifdef SEQ_PERF_CNT_EN
    .CycleCnt(a_cyc), .RetireCnt(a_ret),
`endif
    .Done(a_done)
  );

  instr_sequencer #(.PC_W(4), .LD_LAT(1), .START_PC(0)) dut_b (
    .Clk(Clk), .Reset(b_rst), .Start(b_start), .Branch(b_br), .Immed(b_imm),
    .Taken(b_tk), .MemtoReg(b_ld), .MemWrite(b_st), .Halt(b_halt), .Target(b_tgt),
    .PC(b_pc), .CommitEn(b_commit), .MemWriteEn(b_mwe),
`ifdef SEQ_PERF_CNT_EN
    .CycleCnt(b_cyc), .RetireCnt(b_ret),
`endif
    .Done(b_done)
  );

  localparam logic [7:0] NOP = 8'h00, I_RST = 8'h80, I_S = 8'h40, I_B = 8'h20, I_I = 8'h10;
  localparam logic [7:0] I_T = 8'h08, I_L = 8'h04, I_W = 8'h02, I_H = 8'h01;

  typedef struct {
    string      tag;
    logic [9:0] pc;
    logic       commit;
    logic       mwe;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input bit sel);
    exp_t       e;
    logic [9:0] o_pc;
    logic       o_c, o_m, o_d;
    e    = sb.pop_front();
    o_pc = sel ? {6'd0, b_pc} : a_pc;
    o_c  = sel ? b_commit : a_commit;
    o_m  = sel ? b_mwe : a_mwe;
    o_d  = sel ? b_done : a_done;
    n_cmp++;
    assert (o_pc === e.pc) else begin
      n_fail++; $error("FAIL %s.pc observed=%0d expected=%0d", e.tag, o_pc, e.pc);
    end
    n_cmp++;
    assert (o_c === e.commit) else begin
      n_fail++; $error("FAIL %s.commit observed=%b expected=%b", e.tag, o_c, e.commit);
    end
    n_cmp++;
    assert (o_m === e.mwe) else begin
      n_fail++; $error("FAIL %s.memwe observed=%b expected=%b", e.tag, o_m, e.mwe);
    end
    n_cmp++;
    assert (o_d === e.done) else begin
      n_fail++; $error("FAIL %s.done observed=%b expected=%b", e.tag, o_d, e.done);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, queue the expectation, check 1 ns later.
  task automatic step(input bit sel, input string tag, input logic [7:0] in, input logic [9:0] tgt,
                      input logic [9:0] epc, input logic ec, input logic em, input logic ed);
    exp_t e;
    @(negedge Clk);
    if (!sel) begin
      {a_rst, a_start, a_br, a_imm, a_tk, a_ld, a_st, a_halt} = in;
      a_tgt = tgt;
    end else begin
      {b_rst, b_start, b_br, b_imm, b_tk, b_ld, b_st, b_halt} = in;
      b_tgt = tgt[3:0];
    end
    e.tag = tag; e.pc = epc; e.commit = ec; e.mwe = em; e.done = ed;
    sb.push_back(e);
    #1;
    check(sel);
  endtask

`ifdef SEQ_PERF_CNT_EN
  task automatic check_perf(input string tag, input logic [15:0] ecyc, input logic [15:0] eret);
    n_cmp++;
    assert (b_cyc === ecyc) else begin
      n_fail++; $error("FAIL %s.cycle observed=%0d expected=%0d", tag, b_cyc, ecyc);
    end
    n_cmp++;
    assert (b_ret === eret) else begin
      n_fail++; $error("FAIL %s.retire observed=%0d expected=%0d", tag, b_ret, eret);
    end
  endtask
`endif

  initial begin
    {a_rst, a_start, a_br, a_imm, a_tk, a_ld, a_st, a_halt} = I_RST;
    {b_rst, b_start, b_br, b_imm, b_tk, b_ld, b_st, b_halt} = I_RST;
    a_tgt = '0;
    b_tgt = '0;
    repeat (2) @(posedge Clk);

    // Wide config: start, straight line, load, store, branches.
    step(0, "a_reset_idle", NOP,        0,  0, 0, 0, 0);
    step(0, "a_start_idle", I_S,        0,  0, 0, 0, 0);
    step(0, "a_start_held", I_S,        0,  0, 0, 0, 0);
    step(0, "a_run0",       NOP,        0,  0, 1, 0, 0);
    step(0, "a_run1",       NOP,        0,  1, 1, 0, 0);
    step(0, "a_run2",       NOP,        0,  2, 1, 0, 0);
    step(0, "a_run3",       NOP,        0,  3, 1, 0, 0);
    step(0, "a_run4",       NOP,        0,  4, 1, 0, 0);
    step(0, "a_ld_issue",   I_L,        0,  5, 0, 0, 0);
    step(0, "a_ld_wait",    I_L,        0,  5, 0, 0, 0);
    step(0, "a_ld_commit",  I_L,        0,  5, 1, 0, 0);
    step(0, "a_store",      I_W,        0,  6, 1, 1, 0);
    step(0, "a_alu7",       NOP,        0,  7, 1, 0, 0);
    step(0, "a_br_nt",      I_B,        20, 8, 1, 0, 0);
    step(0, "a_jmp_back",   I_B | I_I,  8,  9, 1, 0, 0);
    step(0, "a_br_tk",      I_B | I_T,  20, 8, 1, 0, 0);
    step(0, "a_jmp8",       I_B | I_I,  8,  20, 1, 0, 0);
    step(0, "a_jmp_imm_nt", I_B | I_I,  20, 8, 1, 0, 0);
    step(0, "a_jmp12",      I_B | I_I,  12, 20, 1, 0, 0);
    // Abort during a load, then reset during a load.
    step(0, "a_ld12",       I_L,        0,  12, 0, 0, 0);
    step(0, "a_ld_abort",   I_L | I_S,  0,  12, 0, 0, 0);
    step(0, "a_after_abort", NOP,       0,  0, 1, 0, 0);
    step(0, "a_ld1",        I_L,        0,  1, 0, 0, 0);
    step(0, "a_rst_mid_ld", I_L | I_RST, 0, 1, 0, 0, 0);
    step(0, "a_rst_idle",   I_L,        0,  0, 0, 0, 0);
    // Halt wins over branch and load; Done holds until Start.
    step(0, "a_restart",    I_S,        0,  0, 0, 0, 0);
    step(0, "a_run_pre_h",  NOP,        0,  0, 1, 0, 0);
    step(0, "a_halt",       I_H | I_B | I_I | I_L, 20, 1, 0, 0, 0);
    step(0, "a_halted1",    NOP,        0,  1, 0, 0, 1);
    step(0, "a_halted_st",  I_W,        0,  1, 0, 0, 1);
    step(0, "a_halt_start", I_S,        0,  1, 0, 0, 1);
    step(0, "a_resumed",    NOP,        0,  0, 1, 0, 0);
    // Branch flag with a load: wait states first, target taken on commit.
    step(0, "a_brld",       I_L | I_B | I_I, 30, 1, 0, 0, 0);
    step(0, "a_brld_wait",  I_L | I_B | I_I, 30, 1, 0, 0, 0);
    step(0, "a_brld_cmt",   I_L | I_B | I_I, 30, 1, 1, 0, 0);
    step(0, "a_at30",       NOP,        0,  30, 1, 0, 0);
    step(0, "a_st_abort",   I_W | I_S,  0,  31, 0, 0, 0);
    step(0, "a_post_abort", NOP,        0,  0, 1, 0, 0);

    // Narrow config: wrap at 15, halt with branch, then counter program.
    step(1, "b_reset_idle", NOP,        0,  0, 0, 0, 0);
    step(1, "b_start",      I_S,        0,  0, 0, 0, 0);
    step(1, "b_jmp15",      I_B | I_I,  15, 0, 1, 0, 0);
    step(1, "b_wrap",       NOP,        0,  15, 1, 0, 0);
    step(1, "b_jmp3",       I_B | I_I,  3,  0, 1, 0, 0);
    step(1, "b_halt_br",    I_H | I_B | I_T, 9, 3, 0, 0, 0);
    step(1, "b_halted1",    NOP,        0,  3, 0, 0, 1);
    step(1, "b_halted2",    NOP,        0,  3, 0, 0, 1);
    step(1, "b_restart",    I_S,        0,  3, 0, 0, 1);
    step(1, "b_p0",         NOP,        0,  0, 1, 0, 0);
`ifdef SEQ_PERF_CNT_EN
    check_perf("b_perf_clear", 16'd0, 16'd0);
`endif
    step(1, "b_p1",         NOP,        0,  1, 1, 0, 0);
    step(1, "b_p2",         NOP,        0,  2, 1, 0, 0);
    step(1, "b_p_ld",       I_L,        0,  3, 0, 0, 0);
    step(1, "b_p_ldc",      I_L,        0,  3, 1, 0, 0);
    step(1, "b_p_halt",     I_H,        0,  4, 0, 0, 0);
    step(1, "b_p_h1",       NOP,        0,  4, 0, 0, 1);
`ifdef SEQ_PERF_CNT_EN
    check_perf("b_perf_halt", 16'd6, 16'd4);
`endif
    step(1, "b_p_h2",       NOP,        0,  4, 0, 0, 1);
`ifdef SEQ_PERF_CNT_EN
    check_perf("b_perf_frozen", 16'd6, 16'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
